// File: rtl/msk_tof_sched_pkg.sv
// Shared sizing helpers for the masked Toffoli scheduler: randomness width,
// requester-id width and the placement of each requester's share lane.
package msk_tof_sched_pkg;

  function automatic int hpc2rnd(input int shares);
    return (shares * (shares - 1)) / 2;
  endfunction

  function automatic int idw(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

  // Lowest bit of requester k's d-share lane inside a packed request bus.
  function automatic int lane_lo(input int k, input int shares);
    return k * shares;
  endfunction

endpackage

// File: rtl/MSKand_hpc2o_tof.sv
// HPC2 masked Toffoli gadget: out = (ina AND inb) XOR inc, share-wise.
// inb and rnd arrive one cycle before ina/inc/inb_prev; out is registered.
module MSKand_hpc2o_tof #(
  parameter int d = 2
) (
  input  logic [d-1:0]             ina,
  input  logic [d-1:0]             inb,
  input  logic [d-1:0]             inb_prev,
  input  logic [d-1:0]             inc,
  input  logic [d*(d-1)/2-1:0]     rnd,
  input  logic                     clk,
  output logic [d-1:0]             out
);

  localparam logic [d-1:0] ONE = {{(d-1){1'b0}}, 1'b1};

  wire [d-1:0] out_w;

  for (genvar i = 0; i < d; i++) begin : g_sh
    localparam logic [d-1:0] OFF = ~(ONE << i);

    wire  [d-1:0] r_row;
    logic [d-1:0] r_q, br_q, u_q, w_q;
    logic         own_q;

    // r_ij == r_ji; pair (lo,hi) maps onto one bit of the triangular rnd word.
    for (genvar j = 0; j < d; j++) begin : g_r
      if (j == i) begin : g_diag
        assign r_row[j] = 1'b0;
      end else begin : g_off
        localparam int LO = (i < j) ? i : j;
        localparam int HI = (i < j) ? j : i;
        localparam int RI = LO*d - (LO*(LO+1))/2 + (HI-LO-1);
        assign r_row[j] = rnd[RI];
      end
    end

    always_ff @(posedge clk) begin
      r_q   <= r_row;
      br_q  <= (inb ^ r_row) & OFF;
      u_q   <= {d{~ina[i]}} & r_q;
      w_q   <= {d{ina[i]}} & br_q;
      own_q <= (ina[i] & inb_prev[i]) ^ inc[i];
    end

    assign out_w[i] = own_q ^ (^u_q) ^ (^w_q);
  end

  assign out = out_w;

endmodule

// File: rtl/msk_rr_arb.sv
// Round-robin arbiter: grants the first requesting index at or above the
// pointer (with wrap-around) and advances the pointer past the winner.
module msk_rr_arb
  import msk_tof_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = idw(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic [IDW-1:0] p;
  logic [IDW:0]   cand;
  logic           found;

  // NOTE: every variable gets a default before the search loop, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, p} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (en && !found && req[cand[IDW-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IDW-1:0]]    = 1'b1;
        gnt_idx               = cand[IDW-1:0];
      end
    end
  end

  // NOTE: blocking assignments above evaluate in order within one cycle;
  // the non-blocking update here lets every flop sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       p <= '0;
    else if (|gnt) p <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/msk_tof_sched.sv
// Round-robin scheduler sharing one HPC2 Toffoli gadget among NREQ
// requesters; each accepted request returns its id with fixed latency 3.
module msk_tof_sched
  import msk_tof_sched_pkg::*;
#(
  parameter  int d       = 2,
  parameter  int NREQ    = 4,
  localparam int HPC2RND = hpc2rnd(d),
  localparam int IDW     = idw(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*d-1:0]   req_a,
  input  logic [NREQ*d-1:0]   req_b,
  input  logic [NREQ*d-1:0]   req_c,
  input  logic                rnd_valid,
  output logic                rnd_ready,
  input  logic [HPC2RND-1:0]  rnd,
  output logic                out_valid,
  output logic [IDW-1:0]      out_id,
  output logic [d-1:0]        out,
  output logic                busy
);

  logic [d-1:0]       lane_a [NREQ];
  logic [d-1:0]       lane_b [NREQ];
  logic [d-1:0]       lane_c [NREQ];
  logic [IDW-1:0]     gnt_idx;
  logic               accept;

  logic [d-1:0]       a0, b0, c0, a1, b1, c1;
  logic [HPC2RND-1:0] rnd0;
  logic               v0, v1, v2;
  logic [IDW-1:0]     id0, id1, id2;

  for (genvar k = 0; k < NREQ; k++) begin : g_lane
    assign lane_a[k] = req_a[lane_lo(k, d) +: d];
    assign lane_b[k] = req_b[lane_lo(k, d) +: d];
    assign lane_c[k] = req_c[lane_lo(k, d) +: d];
  end

  // Issue needs both a request and a fresh rnd word; reset blocks both grants.
  msk_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (rnd_valid & ~rst),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  assign accept    = |req_ready;
  assign rnd_ready = accept;

  // NOTE: share-carrying registers are deliberately left without reset; only
  // the valid/id control path is reset, so no reset net touches share data.
  always_ff @(posedge clk) begin
    if (accept) begin
      a0   <= lane_a[gnt_idx];
      b0   <= lane_b[gnt_idx];
      c0   <= lane_c[gnt_idx];
      rnd0 <= rnd;
    end
    a1 <= a0;
    b1 <= b0;
    c1 <= c0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0  <= 1'b0;
      v1  <= 1'b0;
      v2  <= 1'b0;
      id0 <= '0;
      id1 <= '0;
      id2 <= '0;
    end else begin
      v0  <= accept;
      v1  <= v0;
      v2  <= v1;
      if (accept) id0 <= gnt_idx;
      id1 <= id0;
      id2 <= id1;
    end
  end

  // b leads by one cycle; a, c and the delayed b meet the registered b^r terms.
  MSKand_hpc2o_tof #(.d(d)) u_gadget (
    .ina      (a1),
    .inb      (b0),
    .inb_prev (b1),
    .inc      (c1),
    .rnd      (rnd0),
    .clk      (clk),
    .out      (out)
  );

  assign out_valid = v2;
  assign out_id    = id2;
  assign busy      = v0 | v1 | v2;

endmodule

// File: tb/tb_msk_tof_sched.sv
// Scoreboard bench for msk_tof_sched: driver predicts grants and unmasked
// results, a separate monitor pops and compares whenever results are due.
module tb_msk_tof_sched;

  localparam int D    = 2;
  localparam int NREQ = 4;
  localparam int RW   = 1;
  localparam int IDW  = 2;
  localparam int W    = NREQ*D;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [W-1:0]    req_a, req_b, req_c;
  logic            rnd_valid, rnd_ready;
  logic [RW-1:0]   rnd;
  logic            out_valid;
  logic [IDW-1:0]  out_id;
  logic [D-1:0]    out;
  logic            busy;

  always #5 clk = ~clk;

  msk_tof_sched #(.d(D), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd       (rnd),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out       (out),
    .busy      (busy)
  );

  typedef struct {
    int id;
    bit val;
    int acc;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   p_ref    = 0;
  int   n_ops    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Random d-share encoding of a single bit.
  function automatic logic [D-1:0] share(input bit val);
    logic [D-1:0] s;
    s = D'($urandom);
    s[D-1] = (^s[D-2:0]) ^ val;
    return s;
  endfunction

  // One cycle of stimulus; the reference decides the grant from the
  // round-robin rule and queues the unmasked (a&b)^c result 3 cycles out.
  task automatic drive(input logic [NREQ-1:0] v, input logic rv, input logic r,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [RW-1:0] w);
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [D-1:0] la, lb, lc;
    @(posedge clk);
    #1;
    if (r) while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    rst = r; req_valid = v; req_a = a; req_b = b; req_c = c;
    rnd_valid = rv; rnd = w;
    #1;
    g = -1;
    if (!r && rv)
      for (int i = 0; i < NREQ; i++)
        if (g < 0 && v[(p_ref+i) % NREQ]) g = (p_ref+i) % NREQ;
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rnd_ready", 32'(rnd_ready), 32'(g >= 0));
    if (g >= 0) begin
      la = D'(a >> (g*D));
      lb = D'(b >> (g*D));
      lc = D'(c >> (g*D));
      sb.push_back('{id: g, val: ((^la) & (^lb)) ^ (^lc), acc: cyc, due: cyc + 3});
      p_ref = (g + 1) % NREQ;
      n_ops++;
    end
    if (r) p_ref = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
  endtask

  // Monitor: result timing, id and unmasked value; busy tracks in-flight ops.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst) check("busy", 32'(busy), 32'(sb.size() > 0 && sb[0].acc < cyc));
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("out_valid", 32'(out_valid), 32'd1);
        if (out_valid === 1'b1) begin
          check("out_id", 32'(out_id), 32'(e.id));
          check("out_data", 32'(^out), 32'(e.val));
        end
      end else begin
        check("out_valid_idle", 32'(out_valid), 32'd0);
      end
    end
  end

  initial begin
    logic [W-1:0] da, db, dc;
    int start, guard;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
    rnd_valid = 1'b0; rnd = '0;
    repeat (3) drive('0, 1'b1, 1'b1, '0, '0, '0, '0);

    // Single request from requester 2: a=1, b=1, c=0 then c=1.
    da = '0; db = '0; dc = '0;
    da[2*D +: D] = 2'b01;
    db[2*D +: D] = 2'b10;
    drive(4'b0100, 1'b1, 1'b0, da, db, dc, 1'b1);
    idle(4);
    dc[2*D +: D] = 2'b01;
    drive(4'b0100, 1'b1, 1'b0, da, db, dc, 1'b1);
    idle(4);

    // Fresh pointer, all requesters busy: grants 0,1,2,3,... each cycle.
    drive('0, 1'b1, 1'b1, '0, '0, '0, '0);
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        da[k*D +: D] = share(1'b1);
        db[k*D +: D] = share(1'b1);
        dc[k*D +: D] = share(k % 2 == 1);
      end
      drive('1, 1'b1, 1'b0, da, db, dc, RW'($urandom));
    end

    // rnd_valid 1,0,0,1 with requests pending.
    drive('1, 1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    drive('1, 1'b0, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    drive('1, 1'b0, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    drive('1, 1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    idle(4);

    // Reset right after two back-to-back accepts discards both.
    drive('1, 1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    drive('1, 1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    drive('1, 1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    drive('0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive('0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive('0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive('0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive(4'b1010, 1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));

    // Requester 1 raises and drops valid while rnd is stalled.
    drive(4'b0010, 1'b0, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    drive(4'b0010, 1'b0, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    drive('0, 1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    drive(4'b1001, 1'b1, 1'b0, W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
    idle(4);

    // Randomized traffic: 10,000 issued operations.
    start = n_ops;
    guard = 0;
    while (n_ops - start < 10000 && guard < 40000) begin
      drive(NREQ'($urandom), ($urandom % 4) != 0, 1'b0,
            W'($urandom), W'($urandom), W'($urandom), RW'($urandom));
      guard++;
    end
    check("random_ops_issued", 32'(n_ops - start >= 10000), 32'd1);

    idle(6);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
